// File: rtl/ws2812_pkg.sv
// Shared definitions for the WS2812B transmitter and receiver: the receiver
// state encoding, the transmitter timing terminal counts, and the default
// decode thresholds. Both ends import this package so their timing stays in step.
package ws2812_pkg;

    // Receiver decode states.
    typedef enum logic [1:0] {
        WAIT_GAP = 2'd0,  // Hold off decoding until a full low gap is seen.
        IDLE     = 2'd1,  // Gap seen; waiting for the first rising edge.
        HIGH     = 2'd2,  // Measuring the width of a high pulse.
        LOW      = 2'd3   // Between pulses; watching for the inter-frame gap.
    } rx_state_t;

    // Transmitter terminal counts at 40 MHz. The transmitter counts from 0
    // to these values, so each phase lasts one cycle longer than its count.
    localparam int TX_T0H_CNT = 16;
    localparam int TX_T1H_CNT = 32;
    localparam int TX_T0L_CNT = 34;
    localparam int TX_T1L_CNT = 18;
    localparam int TX_GAP_CNT = 2000;

    // Receiver defaults, chosen between the transmitter's 0 and 1 high widths.
    localparam int HIGH_THRESH_DEF = 24;
    localparam int MIN_HIGH_DEF    = 4;
    localparam int MAX_HIGH_DEF    = 64;
    localparam int RESET_LOW_DEF   = 1000;
    localparam int PIX_W_DEF       = 9;

endpackage

// File: rtl/ws2812_rx_if.sv
// Decoder-side bundle: the serial line in, and the decoded pixel and frame
// outputs. The master drives the line; the slave is the decoder.
interface ws2812_rx_if
    import ws2812_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF
) ();

    logic             din;
    logic [23:0]      pixel;
    logic             pixel_valid;
    logic [PIX_W-1:0] pixel_idx;
    logic             frame_done;
    logic [PIX_W-1:0] pixel_count;
    logic             err;

    modport master (
        output din,
        input  pixel, pixel_valid, pixel_idx, frame_done, pixel_count, err
    );

    modport slave (
        input  din,
        output pixel, pixel_valid, pixel_idx, frame_done, pixel_count, err
    );

endinterface

// File: rtl/ws2812_rx_sync2.sv
// Two-flop synchronizer bringing the asynchronous serial line into clk.
module sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw line through two flops; the first may go metastable.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source, giving a true two-stage shift.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/ws2812_rx.sv
// WS2812B single-wire stream decoder. Measures each high pulse on the
// synchronized line, turns it into a 0/1 bit, packs 24 bits per pixel
// (first bit received lands in pixel[0]) and reports the end of a frame
// when the line stays low for RESET_LOW cycles.
module ws2812_rx
    import ws2812_pkg::*;
#(
    parameter int HIGH_THRESH = HIGH_THRESH_DEF,
    parameter int MIN_HIGH    = MIN_HIGH_DEF,
    parameter int MAX_HIGH    = MAX_HIGH_DEF,
    parameter int RESET_LOW   = RESET_LOW_DEF,
    parameter int PIX_W       = PIX_W_DEF
) (
    input  logic       clk,
    input  logic       reset,
    ws2812_rx_if.slave rx
);

    // One counter serves high widths and low runs; it must reach both the
    // gap length and one past the longest legal high pulse.
    localparam int CNT_TOP = (RESET_LOW > MAX_HIGH + 1) ? RESET_LOW : MAX_HIGH + 1;
    localparam int CNT_W   = $clog2(CNT_TOP + 1);

    logic ds;
    logic ds_prev_q;
    logic rise;
    logic fall;

    rx_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [23:0]      word_q, word_d;
    logic [23:0]      word_new;
    logic [PIX_W-1:0] idx_q, idx_d;
    logic [PIX_W-1:0] idx_inc;

    logic [23:0]      pixel_q, pixel_d;
    logic             pixel_valid_q, pixel_valid_d;
    logic [PIX_W-1:0] pixel_idx_q, pixel_idx_d;
    logic             frame_done_q, frame_done_d;
    logic [PIX_W-1:0] pixel_count_q, pixel_count_d;
    logic             err_q, err_d;

    sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (rx.din),
        .q_o   (ds)
    );

    assign rise = ds & ~ds_prev_q;
    assign fall = ~ds & ds_prev_q;

    // Counters saturate so a stuck line can never wrap back into range.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign idx_inc = (idx_q == '1) ? idx_q : idx_q + 1'b1;

    // Next-state and output decode for the pulse classifier.
    // NOTE: every variable written here gets a default first, so no path
    // leaves one unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bitcnt_d      = bitcnt_q;
        word_d        = word_q;
        word_new      = word_q;
        idx_d         = idx_q;
        pixel_d       = pixel_q;
        pixel_idx_d   = pixel_idx_q;
        pixel_count_d = pixel_count_q;
        pixel_valid_d = 1'b0;
        frame_done_d  = 1'b0;
        err_d         = 1'b0;

        case (state_q)
            WAIT_GAP: begin
                if (ds) begin
                    cnt_d = '0;
                end else if (cnt_inc >= CNT_W'(RESET_LOW)) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            IDLE: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = HIGH;
                end
            end

            HIGH: begin
                if (fall) begin
                    if (cnt_q < CNT_W'(MIN_HIGH)) begin
                        // Glitch: drop the partial word and resync on a gap.
                        err_d    = 1'b1;
                        cnt_d    = '0;
                        bitcnt_d = '0;
                        idx_d    = '0;
                        state_d  = WAIT_GAP;
                    end else begin
                        word_new[bitcnt_q] = (cnt_q >= CNT_W'(HIGH_THRESH));
                        word_d  = word_new;
                        cnt_d   = CNT_W'(1);
                        state_d = LOW;
                        if (bitcnt_q == 5'd23) begin
                            pixel_d       = word_new;
                            pixel_valid_d = 1'b1;
                            pixel_idx_d   = idx_q;
                            idx_d         = idx_inc;
                            bitcnt_d      = '0;
                        end else begin
                            bitcnt_d = bitcnt_q + 1'b1;
                        end
                    end
                end else if (cnt_inc > CNT_W'(MAX_HIGH)) begin
                    // Pulse too long to be a WS2812 bit.
                    err_d    = 1'b1;
                    cnt_d    = '0;
                    bitcnt_d = '0;
                    idx_d    = '0;
                    state_d  = WAIT_GAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            LOW: begin
                if (rise) begin
                    cnt_d   = CNT_W'(1);
                    state_d = HIGH;
                end else if (cnt_inc >= CNT_W'(RESET_LOW)) begin
                    // End of frame; a partial word is reported and dropped.
                    frame_done_d  = 1'b1;
                    err_d         = (bitcnt_q != 5'd0);
                    pixel_count_d = idx_q;
                    idx_d         = '0;
                    bitcnt_d      = '0;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end

            default: begin
                cnt_d    = '0;
                bitcnt_d = '0;
                idx_d    = '0;
                state_d  = WAIT_GAP;
            end
        endcase
    end

    // State, counters and registered outputs; reset forces a fresh gap wait.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ds_prev_q     <= 1'b0;
            state_q       <= WAIT_GAP;
            cnt_q         <= '0;
            bitcnt_q      <= '0;
            word_q        <= '0;
            idx_q         <= '0;
            pixel_q       <= '0;
            pixel_valid_q <= 1'b0;
            pixel_idx_q   <= '0;
            frame_done_q  <= 1'b0;
            pixel_count_q <= '0;
            err_q         <= 1'b0;
        end else begin
            ds_prev_q     <= ds;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bitcnt_q      <= bitcnt_d;
            word_q        <= word_d;
            idx_q         <= idx_d;
            pixel_q       <= pixel_d;
            pixel_valid_q <= pixel_valid_d;
            pixel_idx_q   <= pixel_idx_d;
            frame_done_q  <= frame_done_d;
            pixel_count_q <= pixel_count_d;
            err_q         <= err_d;
        end
    end

    assign rx.pixel       = pixel_q;
    assign rx.pixel_valid = pixel_valid_q;
    assign rx.pixel_idx   = pixel_idx_q;
    assign rx.frame_done  = frame_done_q;
    assign rx.pixel_count = pixel_count_q;
    assign rx.err         = err_q;

endmodule
